csa_cpa_resolver_seq: RTL

//   Converts a carry-save pair (sum vector + carry vector) from the 3:2 CSA compressor

---
 rtl/csa_cpa_resolver_seq_if.sv | 26 ++
 rtl/csa_cpa_resolver_seq.sv | 102 ++++++++++
 2 files changed

// File: rtl/csa_cpa_resolver_seq_if.sv
// Valid/ready bundle between the CSA tree, the resolver and the accumulate path.
// A side moves a beat on a rising edge where its valid and ready are both high; valid is held until then.
interface csa_cpa_resolver_seq_if #(
    parameter int S_WIDTH   = 24,
    parameter int C_WIDTH   = 25,
    parameter int OUT_WIDTH = 26
);
    logic                 in_valid;
    logic                 in_ready;
    logic [S_WIDTH-1:0]   in_sum;
    logic [C_WIDTH-1:0]   in_carry;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_result;
    logic                 busy;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/csa_cpa_resolver_seq.sv
// Slice-serial carry-propagate adder that collapses a CSA sum/carry pair into one
// binary result, SLICE bits per cycle, with valid/ready on both sides.
module csa_cpa_resolver_seq #(
    parameter int S_WIDTH   = 24,
    parameter int C_WIDTH   = 25,
    parameter int OUT_WIDTH = 26,
    parameter int SLICE     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    csa_cpa_resolver_seq_if.slave       bus,
    output logic [1:0]                  o_dbg_state
);
    localparam int NSLICE = (OUT_WIDTH + SLICE - 1) / SLICE;
    localparam int PAD    = NSLICE * SLICE;
    localparam int CNT_W  = $clog2(NSLICE + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PAD-1:0]       r_a;
    logic [PAD-1:0]       r_b;
    logic                 r_carry;
    logic [CNT_W-1:0]     r_cnt;
    logic [OUT_WIDTH-1:0] r_res;
    logic [SLICE:0]       w_sum;
    logic [OUT_WIDTH-1:0] w_res_next;
    logic                 w_last;

    assign w_last = (r_cnt == CNT_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_next = ST_ADD;
            ST_ADD:  if (w_last)       w_state_next = ST_HOLD;
            ST_HOLD: if (bus.out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operands shift down one slice per cycle, so the low slice is always the one being added.
    assign w_sum = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]} + {{SLICE{1'b0}}, r_carry};

    // Only the bits of the current slice that fall below OUT_WIDTH are written.
    always_comb begin
        w_res_next = r_res;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (CNT_W'(i / SLICE) == r_cnt) begin
                w_res_next[i] = w_sum[i % SLICE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= PAD'(bus.in_sum);
                        r_b     <= PAD'(bus.in_carry);
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ST_ADD: begin
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    r_carry <= w_sum[SLICE];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_res   <= w_res_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ST_IDLE) & ~rst;
    assign bus.out_valid  = (r_state == ST_HOLD);
    assign bus.out_result = r_res;
    assign bus.busy       = (r_state == ST_ADD) | (r_state == ST_HOLD);
    assign o_dbg_state    = r_state;
endmodule
